// File: rtl/mem_pkg.sv
// Shared definitions for the byte-memory copy initiator: FSM states and bus widths.
package mem_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W     = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      DONE = 3'd3,
      FILL = 3'd4
   } state_t;

endpackage

// File: rtl/mem_copy.sv
// Block copy initiator for the single-port byte memory: one read/write pair per byte.
// Optional MEM_COPY_FILL_EN adds a constant-fill mode (fill/fill_byte ports).
module mem_copy
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_COPY_FILL_EN
   ,
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_byte
`endif
);

   state_t            state, state_next;
   logic [ADDR_W-1:0] src_ptr, dst_ptr;
   logic [LEN_W-1:0]  count;
`ifdef MEM_COPY_FILL_EN
   logic              fill_q;
   logic [DATA_W-1:0] fill_byte_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_ptr <= '0;
         dst_ptr <= '0;
         count   <= '0;
`ifdef MEM_COPY_FILL_EN
         fill_q      <= 1'b0;
         fill_byte_q <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (start && len != '0) begin
               src_ptr <= src;
               dst_ptr <= dst;
               count   <= len;
`ifdef MEM_COPY_FILL_EN
               fill_q      <= fill;
               fill_byte_q <= fill_byte;
`endif
            end
            WR: begin
               src_ptr <= src_ptr + ADDR_W'(1);
               dst_ptr <= dst_ptr + ADDR_W'(1);
               count   <= count - LEN_W'(1);
            end
`ifdef MEM_COPY_FILL_EN
            FILL: begin
               dst_ptr <= dst_ptr + ADDR_W'(1);
               count   <= count - LEN_W'(1);
            end
`endif
            default: ;
         endcase
      end
   end

   // Outputs decode from the state register only, so reset clears them asynchronously.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state)
         IDLE: if (start) begin
            if (len == '0) state_next = DONE;
`ifdef MEM_COPY_FILL_EN
            else if (fill) state_next = FILL;
`endif
            else           state_next = RD;
         end
         RD: begin
            busy       = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = src_ptr;
            state_next = WR;
         end
         WR: begin
            busy       = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = dst_ptr;
            mem_wdata  = mem_rdata;
            state_next = (count == LEN_W'(1)) ? DONE : RD;
         end
`ifdef MEM_COPY_FILL_EN
         FILL: begin
            busy       = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = dst_ptr;
            mem_wdata  = fill_byte_q;
            state_next = (count == LEN_W'(1)) ? DONE : FILL;
         end
`endif
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_copy.sv
// Self-checking bench for mem_copy with a behavioural byte memory as responder.
// Build with MEM_COPY_FILL_EN to also exercise fill mode.
module tb_mem_copy;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] src = '0, dst = '0, len = '0;
   logic        fill = 1'b0;
   logic [7:0]  fill_byte = '0;
   logic        busy, done, mem_read, mem_write;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   int checks = 0;
   int passed = 0;

   mem_copy #(.ADDR_W(16), .LEN_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
      .busy(busy), .done(done), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_COPY_FILL_EN
      , .fill(fill), .fill_byte(fill_byte)
`endif
   );

   always #5 clk = ~clk;

   // Responder memory: registered read data, write on the clock edge.
   logic [7:0] mem [0:65535];
   logic [7:0] rd_q = '0;
   assign mem_rdata = rd_q;
   always @(posedge clk) begin
      if (mem_read)  rd_q <= mem[mem_addr];
      if (mem_write) mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [15:0] wrap(input logic [15:0] base, input int off);
      return base + 16'(off);
   endfunction

   // Transaction model: m_k counts cycles since acceptance; a copy spends 2*len
   // cycles alternating read/write, a fill len write cycles, then one done cycle.
   logic [7:0]  shadow [0:65535];
   int          m_k = -1;
   int          m_total = 0;
   logic [15:0] m_src = '0, m_dst = '0;
   logic        m_fill = 1'b0;
   logic [7:0]  m_fbyte = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_k = -1;
      else if (m_k < 0 || m_k > m_total) begin
         if (start) begin
            m_src   = src;
            m_dst   = dst;
`ifdef MEM_COPY_FILL_EN
            m_fill  = fill;
            m_fbyte = fill_byte;
`else
            m_fill  = 1'b0;
`endif
            m_total = m_fill ? int'(len) : 2 * int'(len);
            m_k     = 0;
         end
      end else begin
         if (m_k < m_total) begin
            if (m_fill) shadow[wrap(m_dst, m_k)] = m_fbyte;
            else if (m_k % 2 == 1) shadow[wrap(m_dst, m_k / 2)] = shadow[wrap(m_src, m_k / 2)];
         end
         m_k++;
      end
   end

   always @(negedge clk) begin
      logic        e_busy, e_done, e_rd, e_wr;
      logic [15:0] e_addr;
      logic [7:0]  e_wd;
      e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
      if (rst_n && m_k >= 0 && m_k < m_total) begin
         e_busy = 1;
         if (m_fill) begin
            e_wr = 1; e_addr = wrap(m_dst, m_k); e_wd = m_fbyte;
         end else if (m_k % 2 == 0) begin
            e_rd = 1; e_addr = wrap(m_src, m_k / 2);
         end else begin
            e_wr = 1; e_addr = wrap(m_dst, m_k / 2); e_wd = shadow[wrap(m_src, m_k / 2)];
         end
      end else if (rst_n && m_k == m_total) e_done = 1;
      check("bus {busy,done,rd,wr,addr}", {12'h0, busy, done, mem_read, mem_write, mem_addr},
            {12'h0, e_busy, e_done, e_rd, e_wr, e_addr});
      if (e_wr) check("wdata", {24'h0, mem_wdata}, {24'h0, e_wd});
   end

   task automatic poke(input logic [15:0] a, input logic [7:0] v);
      mem[a] = v;
      shadow[a] = v;
   endtask

   int          n_cyc, n_rd, n_wr, busy_seen;
   logic [15:0] rd_addrs [$];

   // Issues a command, returns after done (or timeout) with cycle/strobe stats.
   task automatic run_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input logic f, input logic [7:0] fb);
      bit got;
      @(posedge clk); #2;
      start = 1; src = s; dst = d; len = l; fill = f; fill_byte = fb;
      @(posedge clk); #2;
      start = 0;
      n_cyc = 0; n_rd = 0; n_wr = 0; busy_seen = 0; got = 0;
      rd_addrs.delete();
      while (n_cyc < 200 && !got) begin
         @(negedge clk);
         n_cyc++;
         if (mem_read) begin n_rd++; rd_addrs.push_back(mem_addr); end
         if (mem_write) n_wr++;
         if (busy) busy_seen++;
         if (done) got = 1;
      end
      check("done_seen", {31'h0, got}, 32'h1);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin mem[i] = '0; shadow[i] = '0; end
      #12;
      check("reset outputs", {busy, done, mem_read, mem_write, mem_addr}, '0);
      @(posedge clk); #2 rst_n = 1;

      // Basic 4-byte copy
      poke(16'h10, 8'hAA); poke(16'h11, 8'hBB); poke(16'h12, 8'hCC); poke(16'h13, 8'hDD);
      run_cmd(16'h10, 16'h40, 16'd4, 0, 8'h0);
      check("copy done cycle", n_cyc, 9);
      check("copy reads", n_rd, 4);
      check("copy writes", n_wr, 4);
      @(negedge clk);
      check("copy done single", {31'h0, done}, 0);
      check("mem40", mem[16'h40], 8'hAA);
      check("mem41", mem[16'h41], 8'hBB);
      check("mem42", mem[16'h42], 8'hCC);
      check("mem43", mem[16'h43], 8'hDD);

      // Zero length
      run_cmd(16'h10, 16'h50, 16'd0, 0, 8'h0);
      check("len0 done cycle", n_cyc, 1);
      check("len0 strobes", n_rd + n_wr, 0);
      check("len0 busy", busy_seen, 0);

      // Address wrap on source
      poke(16'hFFFE, 8'h01); poke(16'hFFFF, 8'h02); poke(16'h0000, 8'h03);
      run_cmd(16'hFFFE, 16'h0100, 16'd3, 0, 8'h0);
      check("wrap nreads", rd_addrs.size(), 3);
      if (rd_addrs.size() == 3) begin
         check("wrap rd0", rd_addrs[0], 16'hFFFE);
         check("wrap rd1", rd_addrs[1], 16'hFFFF);
         check("wrap rd2", rd_addrs[2], 16'h0000);
      end
      check("wrap dst2", mem[16'h0102], 8'h03);

      // Overlap with dst > src propagates
      poke(16'h20, 8'h11); poke(16'h21, 8'h22);
      run_cmd(16'h20, 16'h21, 16'd2, 0, 8'h0);
      check("ovl 21", mem[16'h21], 8'h11);
      check("ovl 22", mem[16'h22], 8'h11);

      // Start while busy is ignored
      @(posedge clk); #2;
      start = 1; src = 16'h10; dst = 16'h60; len = 16'd4;
      @(posedge clk); #2 start = 0;
      repeat (3) @(posedge clk);
      #2 start = 1; src = 16'h20; dst = 16'h90; len = 16'd1;
      @(posedge clk); #2 start = 0;
      repeat (8) @(posedge clk);
      #2;
      check("ign mem60", mem[16'h60], 8'hAA);
      check("ign mem63", mem[16'h63], 8'hDD);
      check("ign mem90", mem[16'h90], 8'h00);

      // Reset during the first WR cycle drops the write and the done pulse
      @(posedge clk); #2;
      start = 1; src = 16'h10; dst = 16'h70; len = 16'd4;
      @(posedge clk); #2 start = 0;
      @(negedge clk); @(negedge clk);
      check("pre-reset in WR", {31'h0, mem_write}, 32'h1);
      #2 rst_n = 0;
      #1 check("async reset outputs", {busy, done, mem_read, mem_write, mem_addr}, '0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      repeat (3) @(posedge clk);
      #2 check("reset dropped write", mem[16'h70], 8'h00);

      run_cmd(16'h10, 16'h70, 16'd4, 0, 8'h0);
      check("post-reset done cycle", n_cyc, 9);
      check("post-reset mem70", mem[16'h70], 8'hAA);
      check("post-reset mem73", mem[16'h73], 8'hDD);

`ifdef MEM_COPY_FILL_EN
      run_cmd(16'h0, 16'h80, 16'd3, 1, 8'h5A);
      check("fill done cycle", n_cyc, 4);
      check("fill reads", n_rd, 0);
      check("fill mem80", mem[16'h80], 8'h5A);
      check("fill mem81", mem[16'h81], 8'h5A);
      check("fill mem82", mem[16'h82], 8'h5A);
      check("fill mem83", mem[16'h83], 8'h00);
`endif

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
